ysyx_22050612_lsu: RTL and testbench
====================================

# ysyx_22050612_lsu

Multi-cycle load/store unit that replaces the single-cycle combinational memory read in the execute stage with a handshaked memory transaction. It accepts one load or store per request from the execute stage and drives a valid/ready memory bus. For loads it produces a lane-aligned, sign- or zero-extended result for register writeback. It is parametrised in data width and supports byte/half/word/double accesses, byte-masked stores, misalignment detection and a response timeout.

## Interface
- XLEN, 64: data width; 32 or 64 only.
- TIMEOUT, 255: cycles waited in WAIT for a response before failing with an error; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request from the execute stage.
- in_ready  out  1  LSU can accept a request; high only in IDLE.
- in_wen  in  1  1 = store, 0 = load.
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- in_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- in_addr  in  XLEN  byte address.
- in_wdata  in  XLEN  store data, right-justified.
- in_rd  in  5  destination register tag, returned unchanged.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  XLEN  in_addr with the low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_wmask  out  XLEN/8  byte-lane write enables; all zero for loads.
- mem_resp_valid  in  1  read data or write acknowledgement.
- mem_rdata  in  XLEN  full-width read data.
- out_valid  out  1  single-cycle completion pulse.
- out_rdata  out  XLEN  extended load result; 0 for stores and on error.
- out_rd  out  5  tag of the completed request; 0 for stores.
- out_wen  out  1  register write enable: load completed without error and out_rd != 0.
- out_err  out  1  0 = success, 1 = misaligned access or timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0 except in_ready = 1; wait counter = 0.
- IDLE:
  - On in_valid & in_ready, latch all request fields.
  - Misaligned request (address offset not a multiple of 2^in_size), or in_size = 3 with XLEN = 32: go to DONE with err set. No bus access is made.
  - Otherwise go to REQ.
- Lane and mask computation, with offset = addr mod (XLEN/8):
  - mem_wmask = ((1 << 2^size) - 1) << offset.
  - mem_wdata = wdata << (8 × offset).
- REQ:
  - mem_req_valid = 1. mem_we, mem_addr, mem_wdata and mem_wmask stay stable until the request is accepted.
  - On mem_req_ready, go to WAIT and clear the wait counter.
- WAIT:
  - mem_resp_valid ends the wait. For loads, capture (mem_rdata >> 8 × offset), truncate to 2^size bytes, then sign- or zero-extend to XLEN. Go to DONE with err = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT - 1 with no response, go to DONE with err = 1.
- DONE:
  - out_valid = 1 for exactly one cycle, with registered out_rdata, out_rd, out_wen and out_err.
  - Then return to IDLE.
- Ignored bus inputs: mem_resp_valid outside WAIT (a late response after a timeout is dropped). mem_req_ready outside REQ.
- There is no output backpressure; the writeback stage always consumes out_valid.

## Timing
- Zero-wait bus:
  - Request accepted at edge 0.
  - REQ in cycle 1 with mem_req_ready = 1.
  - WAIT in cycle 2 with mem_resp_valid = 1.
  - out_valid in cycle 3.
- Minimum latency: 3 cycles for a bus access; 1 cycle for a misaligned request (out_valid in the cycle after accept).
- Throughput: at most one request per 4 cycles. in_ready returns high in the cycle after DONE.
- A response in the same cycle as the request handshake is not allowed; the earliest legal response is the first WAIT cycle.
- Reset asserted mid-transaction:
  - mem_req_valid and out_valid drop immediately, without waiting for a clock edge.
  - The FSM goes to IDLE and the pending transaction is discarded.
- All outputs are registered or decoded from the state only. No output depends combinationally on in_* or mem_* inputs.

## Test plan
- Signed byte load:
  - XLEN = 64, addr = 0x80000003, size = 0, unsigned = 0, mem_rdata = 0x00000000_8F000000, rd = 5.
  - Expect mem_addr = 0x80000000, mem_wmask = 0x00, and out_rdata = 0xFFFFFFFF_FFFFFF8F with out_wen = 1 in cycle 3.
- Half store:
  - addr = 0x80000006, size = 1, wdata = 0x1234.
  - Expect mem_wmask = 0xC0, mem_wdata = 0x1234_0000_0000_0000, then out_valid with out_wen = 0 and out_err = 0.
- Misaligned word:
  - addr = 0x80000002, size = 2.
  - Expect mem_req_valid never asserted, out_valid with out_err = 1 in the cycle after accept, out_rdata = 0.
- Bus stalls:
  - mem_req_ready held low for 3 cycles, then response 5 cycles later.
  - Expect bus fields stable throughout REQ and out_valid exactly once, 10 cycles after accept.
- Timeout:
  - TIMEOUT = 4, no response.
  - Expect out_err = 1 after 4 WAIT cycles. A late mem_resp_valid while in IDLE produces no out_valid.
- Reset during WAIT:
  - Expect mem_req_valid = 0 and in_ready = 1 after reset release. The next load (unsigned word, addr 0x80000004, mem_rdata = 0xDEADBEEF_00000000) returns 0x00000000_DEADBEEF.

Source files
------------

// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: turns one execute-stage request into a valid/ready memory transaction
// and returns a lane-aligned, extended load result (3 cycles minimum; 1 for misaligned).
module ysyx_22050612_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic                   wen_q, uns_q;
  logic [1:0]             size_q;
  logic [OW-1:0]          off_q;
  logic [4:0]             rd_q;
  logic [CW-1:0]          cnt;

  logic                   accept, misaligned, resp, timeout;
  logic [OW-1:0]          off_in, align_mask;
  logic [7:0]             mask_base;
  logic [6:0]             sh;
  logic [XLEN-1:0]        shifted, left, load_ext;
  logic signed [XLEN-1:0] sext;

  // Handshake outputs are pure state decodes, so an async reset drops them at once.
  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

  assign accept  = in_valid && (state == IDLE);
  assign off_in  = in_addr[OW-1:0];
  assign resp    = (state == WAIT) && mem_resp_valid;
  assign timeout = (state == WAIT) && !mem_resp_valid && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    align_mask = OW'((4'd1 << in_size) - 4'd1);
    misaligned = (|(off_in & align_mask)) || (in_size == 2'd3 && XLEN == 32);
    unique case (in_size)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      2'd2:    mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  // Move the addressed lanes to bit 0, then push the access to the top and shift back
  // down so the same pair of shifts both truncates and extends.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    sh       = 7'(XLEN) - (7'd8 << size_q);
    left     = shifted << sh;
    sext     = $signed(left) >>> sh;
    load_ext = uns_q ? (left >> sh) : sext;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = misaligned ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (resp || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= '0;
      rd_q      <= 5'd0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      out_rdata <= '0;
      out_rd    <= 5'd0;
      out_wen   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q     <= in_wen;
        uns_q     <= in_unsigned;
        size_q    <= in_size;
        off_q     <= off_in;
        rd_q      <= in_rd;
        mem_we    <= in_wen;
        mem_addr  <= in_addr & ~XLEN'(NB - 1);
        mem_wdata <= in_wdata << {off_in, 3'b000};
        mem_wmask <= in_wen ? (NB'(mask_base) << off_in) : '0;
      end

      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;

      if (accept && misaligned) begin
        out_rdata <= '0;
        out_rd    <= in_wen ? 5'd0 : in_rd;
        out_wen   <= 1'b0;
        out_err   <= 1'b1;
      end else if (resp) begin
        out_rdata <= wen_q ? '0 : load_ext;
        out_rd    <= wen_q ? 5'd0 : rd_q;
        out_wen   <= !wen_q && (rd_q != 5'd0);
        out_err   <= 1'b0;
      end else if (timeout) begin
        out_rdata <= '0;
        out_rd    <= wen_q ? 5'd0 : rd_q;
        out_wen   <= 1'b0;
        out_err   <= 1'b1;
      end else if (state == DONE) begin
        out_rdata <= '0;
        out_rd    <= 5'd0;
        out_wen   <= 1'b0;
        out_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Bench for ysyx_22050612_lsu: scoreboarded loads/stores, stalls, misalignment, timeout, reset.
module tb_ysyx_22050612_lsu;

  typedef struct packed {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } bus_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, t_in_valid, in_wen, in_unsigned;
  logic [1:0]  in_size;
  logic [63:0] in_addr, in_wdata, mem_rdata;
  logic [4:0]  in_rd;
  logic        mem_req_ready, mem_resp_valid;

  logic        in_ready, mem_req_valid, mem_we, out_valid, out_wen, out_err;
  logic [63:0] mem_addr, mem_wdata, out_rdata;
  logic [7:0]  mem_wmask;
  logic [4:0]  out_rd;

  logic        t_in_ready, t_mem_req_valid, t_mem_we, t_out_valid, t_out_wen, t_out_err;
  logic [63:0] t_mem_addr, t_mem_wdata, t_out_rdata;
  logic [7:0]  t_mem_wmask;
  logic [4:0]  t_out_rd;

  int total = 0;
  int bad   = 0;
  res_t sb[$];

  ysyx_22050612_lsu #(.XLEN(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_wen(out_wen), .out_err(out_err)
  );

  ysyx_22050612_lsu #(.XLEN(64), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(t_out_valid), .out_rdata(t_out_rdata), .out_rd(t_out_rd),
    .out_wen(t_out_wen), .out_err(t_out_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd, input bit push, input res_t exp);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      tick;
      g++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: in_ready=%b want 1", in_ready);
    end
    in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_rd = rd;
    in_valid = 1'b1;
    if (push) sb.push_back(exp);
    tick;
    in_valid = 1'b0;
  endtask

  // Acts as the memory: grants after 'stall' REQ cycles, responds in WAIT cycle 'delay'.
  task automatic serve(input string name, input int stall, input int delay,
                       input logic [63:0] rdata, input bus_t ebus,
                       input int elat, input int enreq);
    int   rq, wt, lat, nreq;
    bit   in_wait, seen;
    bus_t gbus;
    res_t exp, got;
    rq = 0; wt = 0; lat = 0; nreq = 0; in_wait = 0; seen = 0;
    mem_rdata = rdata;
    for (int c = 1; c <= 60 && !seen; c++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (out_valid === 1'b1) begin
        seen = 1;
        lat  = c;
      end else begin
        if (mem_req_valid === 1'b1) begin
          nreq++;
          gbus = {mem_we, mem_addr, mem_wdata, mem_wmask};
          total++;
          if (gbus !== ebus) begin
            bad++;
            $display("FAIL %s_bus: got %h want %h", name, gbus, ebus);
          end
          if (rq >= stall) begin
            mem_req_ready = 1'b1;
            in_wait = 1;
          end
          rq++;
        end else if (in_wait) begin
          if (wt == delay) begin
            mem_resp_valid = 1'b1;
            in_wait = 0;
          end
          wt++;
        end
        tick;
      end
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    total++;
    if (lat != elat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d (0 = no out_valid)", name, lat, elat);
    end
    total++;
    if (nreq != enreq) begin
      bad++;
      $display("FAIL %s_req_cycles: got %0d want %0d", name, nreq, enreq);
    end
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {out_rdata, out_rd, out_wen, out_err};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s_result: got %h want %h", name, got, exp);
      end
    end
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_single_pulse: out_valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset;
    logic [210:0] got, exp;
    rst = 1'b1;
    in_valid = 0; t_in_valid = 0; in_wen = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    tick;
    tick;
    got = {in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
           out_valid, out_rdata, out_rd, out_wen, out_err};
    exp = {1'b1, 210'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", got, exp);
    end
    total++;
    if ({t_in_ready, t_mem_req_valid, t_out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL reset_timeout_dut: got %b want 100", {t_in_ready, t_mem_req_valid, t_out_valid});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_signed_byte_load;
    issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 5'd5, 1,
          '{64'hFFFF_FFFF_FFFF_FF8F, 5'd5, 1'b1, 1'b0});
    serve("sbyte", 0, 0, 64'h0000_0000_8F00_0000,
          '{1'b0, 64'h8000_0000, 64'h0, 8'h00}, 3, 1);
  endtask

  task automatic test_half_store;
    issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h1234, 5'd7, 1,
          '{64'h0, 5'd0, 1'b0, 1'b0});
    serve("hstore", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
          '{1'b1, 64'h8000_0000, 64'h1234_0000_0000_0000, 8'hC0}, 3, 1);
  endtask

  task automatic test_misaligned;
    issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 5'd9, 1,
          '{64'h0, 5'd9, 1'b0, 1'b1});
    serve("misalign", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
          '{1'b0, 64'h0, 64'h0, 8'h00}, 1, 0);
  endtask

  task automatic test_bus_stall;
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 5'd12, 1,
          '{64'h0123_4567_89AB_CDEF, 5'd12, 1'b1, 1'b0});
    serve("stall", 3, 4, 64'h0123_4567_89AB_CDEF,
          '{1'b0, 64'h8000_0008, 64'h0, 8'h00}, 10, 4);
  endtask

  task automatic test_load_variants;
    issue(1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'h0, 5'd3, 1,
          '{64'h0000_0000_0000_ABCD, 5'd3, 1'b1, 1'b0});
    serve("uhalf", 0, 0, 64'h0000_0000_ABCD_0000,
          '{1'b0, 64'h8000_0000, 64'h0, 8'h00}, 3, 1);
    issue(1'b0, 2'd2, 1'b0, 64'h8000_0014, 64'h0, 5'd0, 1,
          '{64'hFFFF_FFFF_8000_0001, 5'd0, 1'b0, 1'b0});
    serve("sword_rd0", 0, 1, 64'h8000_0001_1234_5678,
          '{1'b0, 64'h8000_0010, 64'h0, 8'h00}, 4, 1);
    issue(1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h55, 5'd1, 1,
          '{64'h0, 5'd0, 1'b0, 1'b1});
    serve("misalign_dstore", 0, 0, 64'h0,
          '{1'b0, 64'h0, 64'h0, 8'h00}, 1, 0);
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 2'd0, 1'b1, 64'h8000_0031, 64'h0, 5'd20, 1,
          '{64'h0000_0000_0000_00F7, 5'd20, 1'b1, 1'b0});
    serve("b2b_load", 0, 0, 64'h0000_0000_0000_F700,
          '{1'b0, 64'h8000_0030, 64'h0, 8'h00}, 3, 1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready_after_done: in_ready=%b want 1", in_ready);
    end
    issue(1'b1, 2'd0, 1'b0, 64'h8000_0025, 64'hAB, 5'd4, 1,
          '{64'h0, 5'd0, 1'b0, 1'b0});
    serve("b2b_store", 0, 0, 64'h0,
          '{1'b1, 64'h8000_0020, 64'h0000_AB00_0000_0000, 8'h20}, 3, 1);
  endtask

  task automatic test_timeout;
    int   lat;
    res_t exp, got;
    in_wen = 0; in_size = 2'd2; in_unsigned = 0; in_addr = 64'h8000_0000;
    in_wdata = 0; in_rd = 5'd3;
    t_in_valid = 1'b1;
    sb.push_back('{64'h0, 5'd3, 1'b0, 1'b1});
    tick;
    t_in_valid = 1'b0;
    total++;
    if (t_mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL timeout_req: mem_req_valid=%b want 1", t_mem_req_valid);
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    lat = 0;
    for (int c = 2; c <= 30 && lat == 0; c++) begin
      if (t_out_valid === 1'b1) lat = c;
      else tick;
    end
    total++;
    if (lat != 6) begin
      bad++;
      $display("FAIL timeout_latency: got %0d want 6 (0 = no out_valid)", lat);
    end
    exp = sb.pop_front();
    got = {t_out_rdata, t_out_rd, t_out_wen, t_out_err};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL timeout_result: got %h want %h", got, exp);
    end
    tick;
    mem_resp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++;
      if (t_out_valid !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL late_response: out_valid=%b/%b want 0/0", t_out_valid, out_valid);
      end
    end
    mem_resp_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    res_t none;
    none = '0;
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 5'd6, 0, none);
    total++;
    if (mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_pre: mem_req_valid=%b want 1", mem_req_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_req_async_drop: mem_req_valid=%b want 0", mem_req_valid);
    end
    tick;
    rst = 1'b0;
    tick;
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 5'd6, 0, none);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_req_valid, in_ready, out_valid} !== 3'b010) begin
      bad++;
      $display("FAIL rst_wait_state: req/ready/out=%b want 010", {mem_req_valid, in_ready, out_valid});
    end
    tick;
    rst = 1'b0;
    tick;
    total++;
    if ({mem_req_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rst_release: req/ready=%b want 01", {mem_req_valid, in_ready});
    end
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 5'd6, 1,
          '{64'h0000_0000_DEAD_BEEF, 5'd6, 1'b1, 1'b0});
    serve("after_rst", 0, 0, 64'hDEAD_BEEF_0000_0000,
          '{1'b0, 64'h8000_0000, 64'h0, 8'h00}, 3, 1);
  endtask

  initial begin
    test_reset;
    test_signed_byte_load;
    test_half_store;
    test_misaligned;
    test_bus_stall;
    test_load_variants;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
